// File: rtl/wb_openram_bist.sv
// Wishbone classic master that runs a write/read-back self-test over the OpenRAM wrapper port.
// Optional inverted-pattern second pass is enabled with `define WB_OPENRAM_BIST_INVERT_PASS_EN.
module wb_openram_bist #(
    parameter int          ADDR_WIDTH     = 8,
    parameter logic [31:0] SEED           = 32'hA5C3_0F96,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          STOP_ON_FAIL   = 1
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  start_i,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [3:0]            wbm_sel_o,
    output logic [ADDR_WIDTH+1:0] wbm_adr_o,
    output logic [31:0]           wbm_dat_o,
    input  logic                  wbm_ack_i,
    input  logic [31:0]           wbm_dat_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [31:0]           fail_data_o
);

    // Bus handshake: a transfer is the span of cycles with cyc=stb=1; it
    // completes on the first cycle ack is high, and every transfer is followed
    // by one idle gap cycle so a lingering ack can never complete a second one.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_GAP = 3'd2,
        RD_REQ = 3'd3,
        RD_GAP = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [15:0]           TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);

    state_t                state, state_d;
    logic [ADDR_WIDTH-1:0] idx, idx_d;
    logic [15:0]           tcnt, tcnt_d;
    logic                  fail, fail_d;
    logic                  tmo, tmo_d;
    logic [ADDR_WIDTH-1:0] faddr, faddr_d;
    logic [31:0]           fdata, fdata_d;
    logic [31:0]           pattern;
    logic                  last;
    logic                  expired;
`ifdef WB_OPENRAM_BIST_INVERT_PASS_EN
    logic                  inv, inv_d;
`endif

    assign last    = (idx == {ADDR_WIDTH{1'b1}});
    assign expired = (tcnt == TMO_LAST);

`ifdef WB_OPENRAM_BIST_INVERT_PASS_EN
    assign pattern = inv ? ~(SEED ^ 32'(idx)) : (SEED ^ 32'(idx));
`else
    assign pattern = SEED ^ 32'(idx);
`endif

    assign busy_o      = (state != IDLE) && (state != DONE);
    assign done_o      = (state == DONE);
    assign pass_o      = done_o & ~fail & ~tmo;
    assign timeout_o   = tmo;
    assign fail_addr_o = faddr;
    assign fail_data_o = fdata;

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        tcnt_d    = tcnt;
        fail_d    = fail;
        tmo_d     = tmo;
        faddr_d   = faddr;
        fdata_d   = fdata;
`ifdef WB_OPENRAM_BIST_INVERT_PASS_EN
        inv_d     = inv;
`endif
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_we_o  = 1'b0;
        wbm_sel_o = 4'h0;
        wbm_adr_o = '0;
        wbm_dat_o = 32'h0;

        unique case (state)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = WR_REQ;
                    idx_d   = '0;
                    tcnt_d  = '0;
                    fail_d  = 1'b0;
                    tmo_d   = 1'b0;
                    faddr_d = '0;
                    fdata_d = 32'h0;
`ifdef WB_OPENRAM_BIST_INVERT_PASS_EN
                    inv_d   = 1'b0;
`endif
                end
            end
            WR_REQ: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_we_o  = 1'b1;
                wbm_sel_o = 4'hF;
                wbm_adr_o = {idx, 2'b00};
                wbm_dat_o = pattern;
                if (wbm_ack_i) begin
                    state_d = WR_GAP;
                end else if (expired) begin
                    state_d = DONE;
                    tmo_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt + 16'd1;
                end
            end
            WR_GAP: begin
                tcnt_d = '0;
                if (last) begin
                    idx_d   = '0;
                    state_d = RD_REQ;
                end else begin
                    idx_d   = idx + IDX_ONE;
                    state_d = WR_REQ;
                end
            end
            RD_REQ: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_sel_o = 4'hF;
                wbm_adr_o = {idx, 2'b00};
                if (wbm_ack_i) begin
                    state_d = RD_GAP;
                    // Only the first mismatch of the whole test is kept.
                    if ((wbm_dat_i != pattern) && !fail) begin
                        fail_d  = 1'b1;
                        faddr_d = idx;
                        fdata_d = wbm_dat_i;
                    end
                end else if (expired) begin
                    state_d = DONE;
                    tmo_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt + 16'd1;
                end
            end
            RD_GAP: begin
                tcnt_d = '0;
                if (fail && (STOP_ON_FAIL != 0)) begin
                    state_d = DONE;
                end else if (last) begin
`ifdef WB_OPENRAM_BIST_INVERT_PASS_EN
                    if (!inv) begin
                        inv_d   = 1'b1;
                        idx_d   = '0;
                        state_d = WR_REQ;
                    end else begin
                        state_d = DONE;
                    end
`else
                    state_d = DONE;
`endif
                end else begin
                    idx_d   = idx + IDX_ONE;
                    state_d = RD_REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            idx   <= '0;
            tcnt  <= '0;
            fail  <= 1'b0;
            tmo   <= 1'b0;
            faddr <= '0;
            fdata <= 32'h0;
`ifdef WB_OPENRAM_BIST_INVERT_PASS_EN
            inv   <= 1'b0;
`endif
        end else begin
            state <= state_d;
            idx   <= idx_d;
            tcnt  <= tcnt_d;
            fail  <= fail_d;
            tmo   <= tmo_d;
            faddr <= faddr_d;
            fdata <= fdata_d;
`ifdef WB_OPENRAM_BIST_INVERT_PASS_EN
            inv   <= inv_d;
`endif
        end
    end

endmodule

// File: tb/tb_wb_openram_bist.sv
// Scoreboard bench for wb_openram_bist: a 4-word Wishbone memory model with fault modes,
// one DUT with STOP_ON_FAIL=1 and one with STOP_ON_FAIL=0 sharing the model through a mux.
module tb_wb_openram_bist;

    localparam int AW = 2;
    localparam int TW = 1 + 4 + (AW + 2) + 32;
    localparam int RW = 3 + AW + 32;
`ifdef WB_OPENRAM_BIST_INVERT_PASS_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;
    logic sel_dut;

    // ---------------- DUT A (stop on fail) ----------------
    logic          a_cyc, a_stb, a_we, a_ack, a_start, a_busy, a_done, a_pass, a_tmo;
    logic [3:0]    a_sel;
    logic [AW+1:0] a_adr;
    logic [31:0]   a_dato, a_fdata;
    logic [AW-1:0] a_faddr;

    // ---------------- DUT B (continue on fail) ----------------
    logic          b_cyc, b_stb, b_we, b_ack, b_start, b_busy, b_done, b_pass, b_tmo;
    logic [3:0]    b_sel;
    logic [AW+1:0] b_adr;
    logic [31:0]   b_dato, b_fdata;
    logic [AW-1:0] b_faddr;

    logic [31:0] rdat;

    wb_openram_bist #(.ADDR_WIDTH(AW), .SEED(32'hA5C3_0F96), .TIMEOUT_CYCLES(10), .STOP_ON_FAIL(1)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(a_start),
        .wbm_cyc_o(a_cyc), .wbm_stb_o(a_stb), .wbm_we_o(a_we), .wbm_sel_o(a_sel),
        .wbm_adr_o(a_adr), .wbm_dat_o(a_dato), .wbm_ack_i(a_ack), .wbm_dat_i(rdat),
        .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass), .timeout_o(a_tmo),
        .fail_addr_o(a_faddr), .fail_data_o(a_fdata)
    );

    wb_openram_bist #(.ADDR_WIDTH(AW), .SEED(32'hA5C3_0F96), .TIMEOUT_CYCLES(10), .STOP_ON_FAIL(0)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(b_start),
        .wbm_cyc_o(b_cyc), .wbm_stb_o(b_stb), .wbm_we_o(b_we), .wbm_sel_o(b_sel),
        .wbm_adr_o(b_adr), .wbm_dat_o(b_dato), .wbm_ack_i(b_ack), .wbm_dat_i(rdat),
        .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass), .timeout_o(b_tmo),
        .fail_addr_o(b_faddr), .fail_data_o(b_fdata)
    );

    // Selected DUT view
    logic          cyc, stb, we, ack, busy, done, pass, tmo;
    logic [3:0]    sel;
    logic [AW+1:0] adr;
    logic [31:0]   dato, fdata;
    logic [AW-1:0] faddr;

    assign cyc   = sel_dut ? b_cyc   : a_cyc;
    assign stb   = sel_dut ? b_stb   : a_stb;
    assign we    = sel_dut ? b_we    : a_we;
    assign sel   = sel_dut ? b_sel   : a_sel;
    assign adr   = sel_dut ? b_adr   : a_adr;
    assign dato  = sel_dut ? b_dato  : a_dato;
    assign busy  = sel_dut ? b_busy  : a_busy;
    assign done  = sel_dut ? b_done  : a_done;
    assign pass  = sel_dut ? b_pass  : a_pass;
    assign tmo   = sel_dut ? b_tmo   : a_tmo;
    assign faddr = sel_dut ? b_faddr : a_faddr;
    assign fdata = sel_dut ? b_fdata : a_fdata;
    assign a_ack   = !sel_dut && ack;
    assign b_ack   = sel_dut && ack;
    assign a_start = !sel_dut && start;
    assign b_start = sel_dut && start;

    // ---------------- memory model ----------------
    logic [31:0] mem [4];
    logic        ack_q, ack_q2;
    int          fault_mode;
    bit          no_ack, stretch;

    function automatic logic [31:0] corrupt(input logic [AW-1:0] a, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        if (fault_mode == 1 && a == 2'd2) r = r | 32'h0000_0002;
        if (fault_mode == 2 && (a == 2'd1 || a == 2'd3)) r = r ^ 32'h0000_0100;
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            ack_q  <= 1'b0;
            ack_q2 <= 1'b0;
        end else begin
            ack_q2 <= ack_q && stretch;
            if (cyc && stb && !ack_q && !no_ack) begin
                ack_q <= 1'b1;
                if (we) mem[adr[AW+1:2]] <= dato;
                else    rdat <= corrupt(adr[AW+1:2], mem[adr[AW+1:2]]);
            end else begin
                ack_q <= 1'b0;
            end
        end
    end
    assign ack = ack_q | ack_q2;

    // ---------------- scoreboard ----------------
    logic [TW-1:0] exp_q[$];
    logic [RW-1:0] res_q[$];
    logic [31:0]   pat_tab [4] = '{32'hA5C3_0F96, 32'hA5C3_0F97, 32'hA5C3_0F94, 32'hA5C3_0F95};
    int checks = 0;
    int errors = 0;
    int exp_lat, exp_stb;
    bit chk_end, chk_idle;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        logic [TW-1:0] e;
        logic [RW-1:0] r;
        logic done_prev;
        int since, stb_cycles;
        done_prev  = 1'b0;
        since      = 0;
        stb_cycles = 0;
        forever begin
            @(negedge clk);
            if (start && !busy) begin
                since      = 0;
                stb_cycles = 0;
            end else begin
                since++;
                if (cyc && stb) stb_cycles++;
            end
            if (cyc && stb && ack) begin
                check("xfer_expected", 128'(exp_q.size() > 0), 128'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("xfer", 128'({we, sel, adr, (we ? dato : 32'h0)}), 128'(e));
                end
            end
            if (done && !done_prev) begin
                check("result_expected", 128'(res_q.size() > 0), 128'(1));
                if (res_q.size() > 0) begin
                    r = res_q.pop_front();
                    check("result", 128'({busy, pass, tmo, faddr, fdata}), 128'(r));
                    check("latency", 128'(since), 128'(exp_lat));
                    check("stb_cycles", 128'(stb_cycles), 128'(exp_stb));
                    check("xfers_left", 128'(exp_q.size()), 128'(0));
                end
            end
            done_prev = done;
            if (chk_end) check("done_reached", 128'(done), 128'(1));
            if (chk_idle)
                check("idle_outputs",
                      128'({cyc, stb, we, sel, adr, dato, busy, done, pass, tmo, faddr, fdata}), 128'(0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_pass(input bit inv, input int n_wr, input int n_rd);
        logic [31:0]   p;
        logic [AW-1:0] w;
        for (int i = 0; i < n_wr; i++) begin
            w = AW'(i);
            p = inv ? ~pat_tab[i] : pat_tab[i];
            exp_q.push_back({1'b1, 4'hF, w, 2'b00, p});
        end
        for (int i = 0; i < n_rd; i++) begin
            w = AW'(i);
            exp_q.push_back({1'b0, 4'hF, w, 2'b00, 32'h0});
        end
    endtask

    task automatic push_res(input bit p, input bit t, input logic [AW-1:0] fa, input logic [31:0] fd);
        res_q.push_back({1'b0, p, t, fa, fd});
    endtask

    task automatic expect_clean();
        push_pass(1'b0, 4, 4);
        if (INV) push_pass(1'b1, 4, 4);
        push_res(1'b1, 1'b0, 2'd0, 32'h0);
        exp_lat = INV ? 49 : 25;
        exp_stb = INV ? 32 : 16;
    endtask

    task automatic run_test(input int mid_start);
        int n;
        @(posedge clk);
        #1 start = 1'b1;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            start = (n == mid_start);
            if (done) break;
        end
        start   = 1'b0;
        chk_end = 1'b1;
        @(negedge clk);
        #1 chk_end = 1'b0;
    endtask

    task automatic check_idle_now();
        chk_idle = 1'b1;
        @(negedge clk);
        #1 chk_idle = 1'b0;
    endtask

    task automatic reset_mid_third_write();
        int n;
        push_pass(1'b0, 2, 0);
        @(posedge clk);
        #1 start = 1'b1;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            start = 1'b0;
            if (stb && we && adr == 4'h8 && !ack) break;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle_now();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        sel_dut    = 1'b0;
        fault_mode = 0;
        no_ack     = 1'b0;
        stretch    = 1'b0;
        chk_end    = 1'b0;
        chk_idle   = 1'b0;
        exp_lat    = 0;
        exp_stb    = 0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_now();
        rst = 1'b0;

        // Clean memory, then with a start pulse while busy, then with ack held into the gap
        expect_clean();
        run_test(-1);
        expect_clean();
        run_test(7);
        stretch = 1'b1;
        expect_clean();
        run_test(-1);
        stretch = 1'b0;

        // Bit 1 of word 2 stuck at 1: abort after the word-2 read
        fault_mode = 1;
        push_pass(1'b0, 4, 3);
        push_res(1'b0, 1'b0, 2'd2, 32'hA5C3_0F96);
        exp_lat = 22;
        exp_stb = 14;
        run_test(-1);

        // Words 1 and 3 corrupted, stop on fail: no reads of words 2 and 3
        fault_mode = 2;
        push_pass(1'b0, 4, 2);
        push_res(1'b0, 1'b0, 2'd1, 32'hA5C3_0E97);
        exp_lat = 19;
        exp_stb = 12;
        run_test(-1);

        // Slave never acks: stb drops after 10 cycles
        fault_mode = 0;
        no_ack     = 1'b1;
        push_res(1'b0, 1'b1, 2'd0, 32'h0);
        exp_lat = 11;
        exp_stb = 10;
        run_test(-1);
        no_ack = 1'b0;

        // Reset during the third write, then a fresh clean test
        reset_mid_third_write();
        expect_clean();
        run_test(-1);

        // Continue-on-fail instance: every read issued, first failure kept
        sel_dut    = 1'b1;
        fault_mode = 2;
        push_pass(1'b0, 4, 4);
        if (INV) push_pass(1'b1, 4, 4);
        push_res(1'b0, 1'b0, 2'd1, 32'hA5C3_0E97);
        exp_lat = INV ? 49 : 25;
        exp_stb = INV ? 32 : 16;
        run_test(-1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_openram_bist.md
Name: wb_openram_bist

Overview:
- Wishbone classic master that runs a built-in self-test on the dual-port OpenRAM macro through the RAM wrapper's writable Wishbone port (port A or B, as selected by `writable_port_req`).
- Sits directly upstream of the wrapper and drives one wrapper Wishbone slave port.
- Sequence: writes an address-dependent pattern to every word, reads every word back, compares each word, and reports pass/fail with the first failing address and data.
- Used at bring-up, before the CPU is given the RAM.

Parameters:
- ADDR_WIDTH, 8, RAM word-address width; the bus byte address is ADDR_WIDTH+2 bits.
- SEED, 32'hA5C3_0F96, XOR seed for the test pattern.
- TIMEOUT_CYCLES, 255, maximum cycles to wait for ack per transfer (must be ≥1, <65536).
- STOP_ON_FAIL, 1, 1 = abort at the first mismatch; 0 = continue and keep the first failure.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous reset, active-high
- start_i  in  1  one-cycle pulse; starts a test when idle
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  4  byte select; always 4'hF while stb is high, else 0
- wbm_adr_o  out  ADDR_WIDTH+2  byte address = {word_index, 2'b00}
- wbm_dat_o  out  32  write data
- wbm_ack_i  in  1  ack from the wrapper port
- wbm_dat_i  in  32  read data
- busy_o  out  1  test running
- done_o  out  1  test finished; held until the next start or reset
- pass_o  out  1  valid when done_o: no mismatch and no timeout
- timeout_o  out  1  an ack timeout occurred
- fail_addr_o  out  ADDR_WIDTH  word index of the first mismatch
- fail_data_o  out  32  data read at the first mismatch

Behaviour:
- Pattern: P(i) = SEED XOR zero_extend32(i), where i is the word index from 0 to 2^ADDR_WIDTH−1.
- Reset: all outputs 0. State goes to IDLE; counters and failure registers are cleared.
- FSM states: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE.
- IDLE:
  - start_i=1 → WR_REQ, with i=0, busy_o=1, done_o=0, pass_o=0, timeout_o=0, and failure registers cleared.
- WR_REQ:
  - Outputs: cyc=stb=we=1, sel=F, adr={i,00}, dat=P(i).
  - Hold all outputs stable until ack.
  - On ack → WR_GAP.
- WR_GAP:
  - One cycle with cyc=stb=we=0 and sel=0.
  - If i is the last index → RD_REQ with i=0; otherwise i+1 → WR_REQ.
- RD_REQ:
  - Outputs: cyc=stb=1, we=0, sel=F, adr={i,00}.
  - On ack, sample wbm_dat_i in that same cycle.
  - Mismatch with no failure recorded yet: record fail_addr_o=i and fail_data_o=data, and set a sticky fail flag.
  - Then → RD_GAP.
- RD_GAP:
  - One idle bus cycle.
  - Abort condition: fail flag set and STOP_ON_FAIL=1 → DONE.
  - Otherwise, last index → DONE; else i+1 → RD_REQ.
- DONE:
  - busy_o=0, done_o=1, pass_o = ~fail & ~timeout.
  - start_i=1 starts a new test: same actions as from IDLE.
- Latency with a 1-cycle-ack slave:
  - 3 cycles per transfer (request cycle, ack cycle, gap cycle).
  - Total test ≈ 6·2^ADDR_WIDTH cycles, plus 1 cycle to enter DONE.
- Timeout:
  - A per-transfer counter is cleared on entry to each REQ state and counts while in REQ without ack.
  - When it reaches TIMEOUT_CYCLES: drop cyc/stb, set timeout_o=1, go to DONE with pass_o=0. Applies regardless of STOP_ON_FAIL.
- Boundary rules:
  - start_i while busy: ignored.
  - ack arriving in a GAP or IDLE state: ignored.
  - Index wrap-around at the last word is terminal; the counter never wraps into a second pass.
  - The last word is written and verified.
- Reset mid-test: on the next edge, bus outputs are 0 and the FSM is in IDLE. No partial transfer is completed.

Optional Feature:
- Macro: WB_OPENRAM_BIST_INVERT_PASS_EN.
- Defined: after the first read pass completes without abort, a second write pass and a second read pass run using ~P(i).
  - Each bit cell is therefore checked with both 0 and 1.
  - A mismatch in either pass records as described above; only the first mismatch is kept.
  - Total cycles are doubled.
  - A pass-index bit is added to the FSM state.
- Not defined: single write/read pass only. No extra registers exist.

Test Plan:
- ADDR_WIDTH=2, ideal memory model acking 1 cycle after stb, start pulse:
  - Writes to adr 0,4,8,C with data A5C30F96, A5C30F97, A5C30F94, A5C30F95.
  - Then 4 reads.
  - done_o=1, pass_o=1, busy_o=0; at ~25 cycles (≈49 with WB_OPENRAM_BIST_INVERT_PASS_EN).
- Same setup, model forces bit 0 of word 2 stuck-at-0:
  - done_o=1, pass_o=0, fail_addr_o=2, fail_data_o=A5C30F94.
  - Expected data A5C30F94 has bit 0 = 0, so the stuck bit does not show. Bench instead forces bit 1 stuck-at-1 → fail_data_o=A5C30F96.
- STOP_ON_FAIL=1, word 1 and word 3 corrupted:
  - Stops after the word-1 read (no reads to adr 8 or C), fail_addr_o=1.
  - With STOP_ON_FAIL=0: all 4 reads are issued and fail_addr_o stays 1.
- Model never acks, TIMEOUT_CYCLES=10:
  - stb drops after 10 cycles, timeout_o=1, done_o=1, pass_o=0.
- wb_rst_i asserted during the 3rd write with stb high:
  - Next cycle: cyc/stb/busy/done all 0.
  - A fresh start_i then completes with pass_o=1.
- start_i pulsed while busy: no restart; the address sequence is unaffected.
- Ack held high on the gap cycle: no extra transfer is counted.
